// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 parallel-bus read controller.
package ad7606_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } state_e;

  localparam int AD7606_NCHAN = 8;

  localparam logic [2:0] OS_NONE = 3'b000;
  localparam logic [2:0] OS_X2   = 3'b001;
  localparam logic [2:0] OS_X4   = 3'b010;
  localparam logic [2:0] OS_X8   = 3'b011;
  localparam logic [2:0] OS_X16  = 3'b100;
  localparam logic [2:0] OS_X32  = 3'b101;
  localparam logic [2:0] OS_X64  = 3'b110;
  localparam logic [2:0] OS_INV  = 3'b111;

endpackage

// File: rtl/ad7606_ctrl_sync2.sv
// Generic two-flop synchronizer for asynchronous ADC status pins.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-bus read controller: CONVST, BUSY handshake, 8 RD strobes.
// Optional FRSTDATA framing check: define AD7606_FRSTDATA_CHECK_EN.
module ad7606_ctrl
  import ad7606_pkg::*;
#(
  parameter int CONVST_LOW_CYC   = 4,
  parameter int RD_LOW_CYC       = 4,
  parameter int RD_HIGH_CYC      = 2,
  parameter int BUSY_TIMEOUT_CYC = 32768
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  os_i,
  output logic [2:0]  os_o,
  output logic        convstw_o,
  output logic        cs_o,
  output logic        rd_o,
  input  logic        busy_i,
  input  logic        frstdata_i,
  input  logic [15:0] db_i,
  output logic [15:0] data_o,
  output logic [2:0]  chan_o,
  output logic        valid_o,
  output logic        done_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam logic [15:0] CONV_LAST = 16'(CONVST_LOW_CYC - 1);
  localparam logic [15:0] RDL_LAST  = 16'(RD_LOW_CYC - 1);
  localparam logic [15:0] RDH_LAST  = 16'(RD_HIGH_CYC - 1);
  localparam logic [15:0] TO_LAST   = 16'(BUSY_TIMEOUT_CYC - 1);
  localparam logic [2:0]  CH_LAST   = 3'(AD7606_NCHAN - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  ch_q, ch_d;
  logic [2:0]  os_q, os_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  chan_q, chan_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        conv_q, conv_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        busy_s;
  logic        frst_ok;

  sync2 u_busy_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (busy_i),
    .q_o   (busy_s)
  );

`ifdef AD7606_FRSTDATA_CHECK_EN
  logic frst_s;

  sync2 u_frst_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (frstdata_i),
    .q_o   (frst_s)
  );

  // FRSTDATA must mark channel 0 and only channel 0
  assign frst_ok = (frst_s == (ch_q == 3'd0));
`else
  logic unused_frst;
  assign unused_frst = frstdata_i;
  assign frst_ok     = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    os_d    = os_q;
    data_d  = data_q;
    chan_d  = chan_q;
    err_d   = err_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          os_d    = os_i;
          err_d   = 1'b0;
          ch_d    = 3'd0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (busy_s) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_LO: begin
        if (!busy_s) begin
          state_d = S_RD_LO;
        end else if (cnt_q >= TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_LO: begin
        if (cnt_q == RDL_LAST) begin
          data_d  = db_i;
          chan_d  = ch_q;
          valid_d = 1'b1;
          if (!frst_ok) err_d = 1'b1;
          state_d = S_RD_HI;
        end
      end
      S_RD_HI: begin
        if (cnt_q == RDH_LAST) begin
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 3'd1;
            state_d = S_RD_LO;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Phase/wait counter restarts on every state entry and saturates
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == 16'hFFFF) cnt_d = cnt_q;
    else cnt_d = cnt_q + 16'd1;

    // Pins are registered from the next state so they track it exactly
    conv_d = (state_d != S_CONV);
    cs_d   = !((state_d == S_RD_LO) || (state_d == S_RD_HI));
    rd_d   = (state_d != S_RD_LO);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      os_q    <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      conv_q  <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      os_q    <= os_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
    end
  end

  assign os_o      = os_q;
  assign convstw_o = conv_q;
  assign cs_o      = cs_q;
  assign rd_o      = rd_q;
  assign data_o    = data_q;
  assign chan_o    = chan_q;
  assign valid_o   = valid_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign ready_o   = (state_q == S_IDLE);

endmodule

// File: doc/ad7606_ctrl.md
# ad7606_ctrl

FPGA-side read controller for the AD7606 8-channel simultaneous-sampling ADC in parallel-bus mode. On each `start_i` it pulses CONVST, waits for BUSY to rise and fall, then holds CS low and issues eight RD strobes. It captures the 16-bit result on each strobe and presents it as a channel-tagged word on a valid strobe. It sits between the acquisition sequencer and the ADC pins, and is the host end of the convst/cs/rd/busy/frstdata bus.

## Interface
Parameters:
- `CONVST_LOW_CYC`, 4: cycles `convstw_o` is held low (≥ 25 ns at 100 MHz).
- `RD_LOW_CYC`, 4: cycles `rd_o` is low per read; data is sampled on the last of these.
- `RD_HIGH_CYC`, 2: cycles `rd_o` is high between reads.
- `BUSY_TIMEOUT_CYC`, 32768: maximum cycles spent in either BUSY wait state.

Ports:
- `clk_i` input 1: system clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: one-cycle conversion request; ignored unless `ready_o` is high.
- `os_i` input 3: oversampling ratio; registered at start and driven to the ADC.
- `os_o` output 3: OS[2:0] pins.
- `convstw_o` output 1: CONVST, active low.
- `cs_o` output 1: chip select, active low.
- `rd_o` output 1: read strobe, active low.
- `busy_i` input 1: ADC BUSY, asynchronous.
- `frstdata_i` input 1: ADC FRSTDATA, asynchronous.
- `db_i` input 16: ADC data bus.
- `data_o` output 16: captured sample.
- `chan_o` output 3: channel index of `data_o`.
- `valid_o` output 1: one-cycle strobe for `data_o`/`chan_o`.
- `done_o` output 1: one-cycle pulse after channel 7 is delivered.
- `ready_o` output 1: high in IDLE.
- `err_o` output 1: sticky error flag; cleared by `reset_i` or by the next accepted `start_i`.

## Operation
- States: IDLE, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE.
- IDLE: `ready_o`=1. On `start_i`, latch `os_i`, clear `err_o` and the channel counter, go to CONV.
- CONV: `convstw_o`=0 for `CONVST_LOW_CYC` cycles, then go to WAIT_HI.
- WAIT_HI: wait for synchronized BUSY=1, then go to WAIT_LO.
- WAIT_LO: wait for synchronized BUSY=0, then assert `cs_o`=0 and go to RD_LO.
- RD_LO: `rd_o`=0 for `RD_LOW_CYC` cycles. On the last cycle:
  - register `db_i` into `data_o` and the counter into `chan_o`;
  - pulse `valid_o` on the following cycle.
- RD_HI: `rd_o`=1 for `RD_HIGH_CYC` cycles. If the counter is below 7, increment it and go to RD_LO; otherwise go to DONE.
- DONE: `cs_o`=1, pulse `done_o`, return to IDLE.
- Timeout: if the wait counter reaches `BUSY_TIMEOUT_CYC` in WAIT_HI or WAIT_LO, set `err_o`, release the bus and return to IDLE. No `valid_o` and no `done_o` are produced.
- The wait counter is 16 bits, saturating, and cleared on every state entry.
- `start_i` outside IDLE is dropped; no queuing.

## Timing
- Reset values:
  - `convstw_o`=1, `cs_o`=1, `rd_o`=1
  - `os_o`=0, `data_o`=0, `chan_o`=0
  - `valid_o`=0, `done_o`=0, `err_o`=0
  - `ready_o`=1
- State is IDLE during and after reset.
- Reset asserted mid-operation forces all pins to their idle levels asynchronously. The partial burst is abandoned and nothing further is emitted.
- `busy_i` and `frstdata_i` each pass through a 2-flop synchronizer, adding 2 cycles of latency.
- `db_i` is sampled directly on the RD_LO edge. `RD_LOW_CYC` must cover t_DRD plus routing.
- Pin outputs are driven from flops; no combinational paths to pins.
- Burst from WAIT_LO exit to `done_o` is 8·(`RD_LOW_CYC`+`RD_HIGH_CYC`)+1 cycles.
- `valid_o` is 1 cycle wide, and there are at least `RD_HIGH_CYC` cycles between consecutive strobes.
- If BUSY is already high when WAIT_HI is entered, WAIT_HI exits on the first synchronized sample.
- If BUSY pulses high for less than 2 cycles, it may be missed and will end in a timeout error. This is accepted behaviour.

## Configuration
- `AD7606_FRSTDATA_CHECK_EN` defined: synchronized FRSTDATA is sampled with `db_i` on each read.
  - It must be 1 for channel 0 and 0 for channels 1–7.
  - A mismatch sets `err_o`; the burst still completes and all 8 `valid_o` strobes are issued.
- Undefined: `frstdata_i` is ignored and its synchronizer is not instantiated.

## Structure
- Package `ad7606_pkg`:
  - state enum;
  - `AD7606_NCHAN`=8;
  - OS encodings (000 none through 110 ×64; 111 invalid).
- Sub-module `sync2`: generic 2-flop synchronizer with async active-high reset, reused for BUSY and FRSTDATA.

## Test plan
- Nominal, os_i=000: BUSY high 140 ns after CONVST falls, low 4 µs later, data $random per read.
  - Expect 8 `valid_o` with `chan_o` 0..7 matching the bus values, one `done_o`, `err_o`=0.
- `os_i`=011 (×8): BUSY lasts 39 µs.
  - Expect `os_o`=011 throughout and a normal burst.
- BUSY never rises.
  - Expect `err_o`=1 after 32768 cycles in WAIT_HI, bus released, no `valid_o`.
- `reset_i` pulsed during the 4th read (`chan_o`=3).
  - Expect `cs_o`/`rd_o`=1 immediately, no further `valid_o`, `ready_o`=1.
  - A following `start_i` runs a clean burst.
- With `AD7606_FRSTDATA_CHECK_EN`, model drives FRSTDATA high on channel 1 instead of channel 0.
  - Expect `err_o`=1 and all 8 words still delivered.
- `start_i` asserted in WAIT_LO.
  - Expect it ignored: exactly one burst and one `done_o`.
